// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready pipeline register with flush and optional skid entry
//
// Purpose: one-entry (or two-entry with skid) registered pipeline stage for
// the MIPS inter-stage registers. Stall = OutReady low, bubble = OutValid low.
//
// Ports:
//   Clock     in   rising-edge clock
//   NReset    in   asynchronous active-low reset
//   Flush     in   synchronous clear of all held entries
//   DataIn    in   [WIDTH] upstream payload
//   InValid   in   upstream payload valid
//   InReady   out  stage can accept (transfer on InValid && InReady)
//   Q         out  [WIDTH] head entry
//   NQ        out  [WIDTH] ~Q
//   OutValid  out  Q holds a valid entry
//   OutReady  in   downstream accepts (transfer on OutValid && OutReady)
//   Count     out  [2] occupied entries
//
// Build option: define PIPE_STAGE_REG_SKID_EN to add the skid entry, which
// makes InReady a registered signal (no OutReady -> InReady path).

module pipe_stage_reg #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             Clock,
   input  logic             NReset,
   input  logic             Flush,
   input  logic [WIDTH-1:0] DataIn,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] NQ,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [1:0]       Count
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             in_fire;
   logic             out_fire;

   assign in_fire  = InValid & InReady;
   assign out_fire = valid_q & OutReady;

`ifdef PIPE_STAGE_REG_SKID_EN

   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_valid_q, skid_valid_d;

   // Only the Flush gating is combinational; the rest comes from a flop.
   assign InReady = ~skid_valid_q & ~Flush;

   always_comb begin
      data_d       = data_q;
      valid_d      = valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      if (Flush) begin
         // A downstream transfer this cycle still completes; contents go afterwards.
         data_d       = RESET_VALUE;
         valid_d      = 1'b0;
         skid_data_d  = RESET_VALUE;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // Two entries held, InReady is low: only draining is possible.
         if (out_fire) begin
            data_d       = skid_data_q;
            skid_valid_d = 1'b0;
         end
      end else if (valid_q) begin
         if (in_fire && out_fire) begin
            data_d = DataIn;
         end else if (in_fire) begin
            // Downstream stalled: park the beat in the skid entry.
            skid_data_d  = DataIn;
            skid_valid_d = 1'b1;
         end else if (out_fire) begin
            valid_d = 1'b0;
         end
      end else if (in_fire) begin
         data_d  = DataIn;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge NReset) begin
      if (!NReset) begin
         skid_data_q  <= RESET_VALUE;
         skid_valid_q <= 1'b0;
      end else begin
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // valid_q is always set while the skid entry is occupied.
   assign Count = {skid_valid_q, valid_q & ~skid_valid_q};

`else

   assign InReady = (~valid_q | OutReady) & ~Flush;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (Flush) begin
         data_d  = RESET_VALUE;
         valid_d = 1'b0;
      end else if (in_fire) begin
         // Covers both the empty case and the simultaneous in+out case.
         data_d  = DataIn;
         valid_d = 1'b1;
      end else if (out_fire) begin
         valid_d = 1'b0;
      end
   end

   assign Count = {1'b0, valid_q};

`endif

   always_ff @(posedge Clock or negedge NReset) begin
      if (!NReset) begin
         data_q  <= RESET_VALUE;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign Q        = data_q;
   assign NQ       = ~data_q;
   assign OutValid = valid_q;

endmodule
